nco_bank: RTL and testbench

- Parametrised multi-channel numerically controlled oscillator.
- Self-contained: phase accumulators plus a quarter-wave sin/cos ROM, with no vendor DDS core.
- Feeds the DAC path (excitation channels) and the PSD path (reference sin/cos) from one clock domain.
- Over the fixed 4-DDS block it adds:
  - per-channel double-buffered (shadow/active) configuration with atomic commit;
  - synchronous phase clear;
  - per-channel enable with DC-hold output;
  - a parametrised PSD strobe divider.

---
 rtl/nco_pkg.sv | 21 ++
 rtl/nco_sincos_lut.sv | 78 +++++++
 rtl/nco_bank.sv | 114 +++++++++++
 tb/tb_nco_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO bank: phase quadrants, config selects
// and the quarter-wave sine table generator.
package nco_pkg;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

    localparam logic CFG_SEL_INC = 1'b0;
    localparam logic CFG_SEL_OFF = 1'b1;

    // Entry k of the quarter-wave table; the quarter point itself is exact full scale.
    function automatic int quarter_sin(input int k, input int ph_w, input int out_w);
        real amp;
        real x;
        amp = real'((1 << (out_w - 1)) - 1);
        if (k >= (1 << (ph_w - 2)))
            return $rtoi(amp);
        x = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(1 << ph_w));
        return $rtoi(x + 0.5);
    endfunction

endpackage

// File: rtl/nco_sincos_lut.sv
// Per-channel sin/cos lookup: quadrant fold into a registered quarter-wave ROM,
// then conditional negate into the output register (two clocks).
module nco_sincos_lut
    import nco_pkg::*;
#(
    parameter int PH_W  = 12,
    parameter int OUT_W = 16
) (
    input  logic             i_clk_250M,
    input  logic             i_rst_n,
    input  logic             i_vld,     // valid of the ROM stage, gates the output
    input  logic             i_en,      // enable aligned with i_phase
    input  logic [PH_W-1:0]  i_phase,
    output logic [OUT_W-1:0] o_sin,
    output logic [OUT_W-1:0] o_cos
);

    localparam int NQ = 1 << (PH_W - 2);
    localparam logic [PH_W-2:0]  ADDR_NQ = (PH_W-1)'(NQ);
    localparam logic [OUT_W-1:0] AMP     = {1'b0, {(OUT_W-1){1'b1}}};

    // NQ+1 entries so the mirrored quadrants can address the quarter point directly
    logic [OUT_W-1:0] rom [NQ+1];

    for (genvar k = 0; k <= NQ; k++) begin : g_rom
        assign rom[k] = OUT_W'(quarter_sin(k, PH_W, OUT_W));
    end

    function automatic logic [PH_W-2:0] fold_addr(input logic [PH_W-1:0] p);
        quad_e           q;
        logic [PH_W-2:0] a;
        q = quad_e'(p[PH_W-1 -: 2]);
        a = {1'b0, p[PH_W-3:0]};
        return (q == Q1 || q == Q3) ? ADDR_NQ - a : a;
    endfunction

    function automatic logic is_neg(input logic [PH_W-1:0] p);
        return quad_e'(p[PH_W-1 -: 2]) inside {Q2, Q3};
    endfunction

    logic [PH_W-1:0]  ph_cos;
    logic [PH_W-2:0]  addr_s, addr_c;
    logic [OUT_W-1:0] mag_s, mag_c;
    logic             neg_s, neg_c, en2;

    assign ph_cos = i_phase + PH_W'(NQ);
    assign addr_s = fold_addr(i_phase);
    assign addr_c = fold_addr(ph_cos);

    always_ff @(posedge i_clk_250M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mag_s <= '0;
            mag_c <= '0;
            neg_s <= 1'b0;
            neg_c <= 1'b0;
            en2   <= 1'b0;
            o_sin <= '0;
            o_cos <= '0;
        end else begin
            mag_s <= rom[addr_s];
            mag_c <= rom[addr_c];
            neg_s <= is_neg(i_phase);
            neg_c <= is_neg(ph_cos);
            en2   <= i_en;
            if (!i_vld) begin
                o_sin <= '0;
                o_cos <= '0;
            end else if (!en2) begin
                o_sin <= AMP;
                o_cos <= '0;
            end else begin
                o_sin <= neg_s ? -mag_s : mag_s;
                o_cos <= neg_c ? -mag_c : mag_c;
            end
        end
    end

endmodule

// File: rtl/nco_bank.sv
// Multi-channel NCO: double-buffered per-channel increment/offset, phase
// accumulators, sin/cos lookup per channel and a divided PSD strobe.
module nco_bank
    import nco_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int ACC_W      = 32,
    parameter int PH_W       = 12,
    parameter int OUT_W      = 16,
    parameter int STROBE_DIV = 250,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  i_clk_250M,
    input  logic                  i_rst_n,
    input  logic                  i_cfg_we,
    input  logic [CH_W-1:0]       i_cfg_ch,
    input  logic                  i_cfg_sel,
    input  logic [ACC_W-1:0]      i_cfg_data,
    input  logic                  i_cfg_commit,
    input  logic                  i_sync_clr,
    input  logic [N_CH-1:0]       i_ch_en,
    output logic [N_CH*OUT_W-1:0] o_sin,
    output logic [N_CH*OUT_W-1:0] o_cos,
    output logic                  o_strobe
);

    localparam int STAGES = 2;
    localparam int SC_W   = $clog2(STROBE_DIV);

    typedef struct packed {
        logic [ACC_W-1:0] inc;
        logic [ACC_W-1:0] off;
    } cfg_t;

    cfg_t [N_CH-1:0] shadow, active;
    logic [STAGES:0] vld_pipe;
    logic [SC_W-1:0] strobe_cnt;

    // Commit reads the pre-edge shadow, so a same-cycle write lands in shadow only
    always_ff @(posedge i_clk_250M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (i_cfg_commit)
                active <= shadow;
            if (i_cfg_we && int'(i_cfg_ch) < N_CH) begin
                if (i_cfg_sel == CFG_SEL_OFF)
                    shadow[i_cfg_ch].off <= i_cfg_data;
                else
                    shadow[i_cfg_ch].inc <= i_cfg_data;
            end
        end
    end

    // Bit 0 is the accumulator stage, valid straight out of reset
    always_ff @(posedge i_clk_250M or negedge i_rst_n) begin
        if (!i_rst_n)
            vld_pipe <= (STAGES+1)'(1);
        else
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic [PH_W-1:0]  ph1;
        logic             en1;

        always_ff @(posedge i_clk_250M or negedge i_rst_n) begin
            if (!i_rst_n) begin
                acc <= '0;
                ph1 <= '0;
                en1 <= 1'b0;
            end else begin
                if (i_sync_clr)
                    acc <= '0;
                else if (i_ch_en[c])
                    acc <= acc + active[c].inc;
                ph1 <= PH_W'((acc + active[c].off) >> (ACC_W - PH_W));
                en1 <= i_ch_en[c];
            end
        end

        nco_sincos_lut #(
            .PH_W  (PH_W),
            .OUT_W (OUT_W)
        ) u_lut (
            .i_clk_250M (i_clk_250M),
            .i_rst_n    (i_rst_n),
            .i_vld      (vld_pipe[STAGES]),
            .i_en       (en1),
            .i_phase    (ph1),
            .o_sin      (o_sin[c*OUT_W +: OUT_W]),
            .o_cos      (o_cos[c*OUT_W +: OUT_W])
        );
    end

    always_ff @(posedge i_clk_250M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            strobe_cnt <= '0;
            o_strobe   <= 1'b0;
        end else if (i_sync_clr) begin
            strobe_cnt <= '0;
            o_strobe   <= 1'b0;
        end else if (strobe_cnt == SC_W'(STROBE_DIV - 1)) begin
            strobe_cnt <= '0;
            o_strobe   <= 1'b1;
        end else begin
            strobe_cnt <= strobe_cnt + SC_W'(1);
            o_strobe   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nco_bank.sv
// Directed bench for nco_bank with a cycle model feeding an expected-output queue.
module tb_nco_bank;

    localparam int N    = 5;
    localparam int CH_W = 3;
    localparam int DIV  = 250;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            cfg_we = 1'b0;
    logic [CH_W-1:0] cfg_ch = '0;
    logic            cfg_sel = 1'b0;
    logic [31:0]     cfg_data = '0;
    logic            cfg_commit = 1'b0;
    logic            sync_clr = 1'b0;
    logic [N-1:0]    ch_en = '1;
    logic [N*16-1:0] o_sin, o_cos;
    logic            o_strobe;

    nco_bank #(.N_CH(N), .ACC_W(32), .PH_W(12), .OUT_W(16), .STROBE_DIV(DIV)) dut (
        .i_clk_250M   (clk),
        .i_rst_n      (rst_n),
        .i_cfg_we     (cfg_we),
        .i_cfg_ch     (cfg_ch),
        .i_cfg_sel    (cfg_sel),
        .i_cfg_data   (cfg_data),
        .i_cfg_commit (cfg_commit),
        .i_sync_clr   (sync_clr),
        .i_ch_en      (ch_en),
        .o_sin        (o_sin),
        .o_cos        (o_cos),
        .o_strobe     (o_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0][15:0] s;
        logic [N-1:0][15:0] c;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] m_sh_inc[N], m_sh_off[N], m_inc[N], m_off[N], m_acc[N];
    int          m_cnt;
    logic        m_strobe;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [15:0] qv(input int k);
        real x;
        if (k == 1024) return 16'h7FFF;
        x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 4096.0);
        return 16'($rtoi(x + 0.5));
    endfunction

    function automatic logic [15:0] wave(input logic [11:0] p);
        int a;
        a = int'(p[9:0]);
        case (p[11:10])
            2'd0:    return qv(a);
            2'd1:    return qv(1024 - a);
            2'd2:    return -qv(a);
            default: return -qv(1024 - a);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_t z;
        for (int c = 0; c < N; c++) begin
            m_sh_inc[c] = '0; m_sh_off[c] = '0;
            m_inc[c] = '0; m_off[c] = '0; m_acc[c] = '0;
        end
        m_cnt = 0;
        m_strobe = 1'b0;
        z.s = '0;
        z.c = '0;
        expq.delete();
        expq.push_back(z);
        expq.push_back(z);
    endtask

    task automatic tick();
        exp_t        e;
        logic [11:0] ph;
        for (int c = 0; c < N; c++) begin
            if (!ch_en[c]) begin
                e.s[c] = 16'h7FFF;
                e.c[c] = 16'h0000;
            end else begin
                ph = 12'((m_acc[c] + m_off[c]) >> 20);
                e.s[c] = wave(ph);
                e.c[c] = wave(ph + 12'd1024);
            end
        end
        expq.push_back(e);
        @(posedge clk);
        for (int c = 0; c < N; c++) begin
            if (sync_clr) m_acc[c] = '0;
            else if (ch_en[c]) m_acc[c] = m_acc[c] + m_inc[c];
        end
        if (cfg_commit)
            for (int c = 0; c < N; c++) begin
                m_inc[c] = m_sh_inc[c];
                m_off[c] = m_sh_off[c];
            end
        if (cfg_we && int'(cfg_ch) < N) begin
            if (cfg_sel) m_sh_off[cfg_ch] = cfg_data;
            else         m_sh_inc[cfg_ch] = cfg_data;
        end
        if (sync_clr) begin
            m_cnt = 0; m_strobe = 1'b0;
        end else if (m_cnt == DIV - 1) begin
            m_cnt = 0; m_strobe = 1'b1;
        end else begin
            m_cnt++; m_strobe = 1'b0;
        end
        #1;
        chk("strobe", 16'(o_strobe), 16'(m_strobe));
        if (expq.size() >= 3) begin
            e = expq.pop_front();
            for (int c = 0; c < N; c++) begin
                chk($sformatf("sin ch%0d", c), o_sin[c*16 +: 16], e.s[c]);
                chk($sformatf("cos ch%0d", c), o_cos[c*16 +: 16], e.c[c]);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < N; c++) begin
            chk($sformatf("rst sin ch%0d", c), o_sin[c*16 +: 16], 16'h0000);
            chk($sformatf("rst cos ch%0d", c), o_cos[c*16 +: 16], 16'h0000);
        end
        chk("rst strobe", 16'(o_strobe), 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst hold cos ch0", o_cos[15:0], 16'h0000);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wr(input int ch, input logic sel, input logic [31:0] d);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_sel = sel; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        int first, second;
        #1;
        do_reset();

        // strobe cadence from release, unconfigured outputs
        first = -1;
        second = -1;
        for (int i = 1; i <= 520; i++) begin
            tick();
            if (o_strobe) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        chk("strobe first", 16'(first), 16'd250);
        chk("strobe second", 16'(second), 16'd500);

        // static phase offsets on ch0
        wr(0, 1'b1, 32'h4000_0000);
        commit();
        repeat (3) tick();
        chk("ch0 off90 sin", o_sin[15:0], 16'h7FFF);
        chk("ch0 off90 cos", o_cos[15:0], 16'h0000);
        wr(0, 1'b1, 32'h8000_0000);
        commit();
        repeat (3) tick();
        chk("ch0 off180 sin", o_sin[15:0], 16'h0000);
        chk("ch0 off180 cos", o_cos[15:0], 16'h8001);

        // ch1 period-16 tone after sync clear
        wr(1, 1'b0, 32'h1000_0000);
        commit();
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        repeat (3) tick();
        chk("ch1 s0", o_sin[31:16], 16'h0000);
        repeat (4) tick();
        chk("ch1 s4", o_sin[31:16], 16'h7FFF);
        repeat (4) tick();
        chk("ch1 s8", o_sin[31:16], 16'h0000);
        repeat (4) tick();
        chk("ch1 s12", o_sin[31:16], 16'h8001);

        // ch2 shadow write without commit, then write+commit together
        wr(2, 1'b0, 32'h0100_0000);
        repeat (100) tick();
        chk("ch2 uncommitted sin", o_sin[47:32], 16'h0000);
        chk("ch2 uncommitted cos", o_cos[47:32], 16'h7FFF);
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_sel = 1'b0; cfg_data = 32'h0200_0000;
        cfg_commit = 1'b1;
        tick();
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        repeat (19) tick();
        chk("ch2 pre-write value", o_sin[47:32], 16'd12539);
        commit();
        repeat (10) tick();

        // ch3 disable/hold/resume, out-of-range write, commit with sync clear
        wr(3, 1'b0, 32'h0123_4567);
        wr(7, 1'b1, 32'hDEAD_BEEF);
        commit();
        repeat (10) tick();
        ch_en = 5'b10111;
        repeat (3) tick();
        chk("ch3 off sin", o_sin[63:48], 16'h7FFF);
        chk("ch3 off cos", o_cos[63:48], 16'h0000);
        repeat (5) tick();
        chk("ch3 held sin", o_sin[63:48], 16'h7FFF);
        ch_en = '1;
        repeat (12) tick();
        wr(3, 1'b1, 32'h2000_0000);
        cfg_commit = 1'b1;
        sync_clr = 1'b1;
        tick();
        cfg_commit = 1'b0;
        sync_clr = 1'b0;
        repeat (8) tick();

        // reset mid-oscillation
        repeat (5) tick();
        do_reset();
        repeat (2) tick();
        chk("post-rst sin ch1", o_sin[31:16], 16'h0000);
        chk("post-rst cos ch0", o_cos[15:0], 16'h0000);
        tick();
        chk("post-rst fill cos ch0", o_cos[15:0], 16'h7FFF);
        chk("post-rst fill sin ch1", o_sin[31:16], 16'h0000);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
